// File: rtl/snn_frame_controller_pkg.sv
// Shared parameters, state encoding and payload types for the SNN frame controller.
package snn_frame_controller_pkg;

   localparam int unsigned PIXEL_WIDTH       = 8;
   localparam int unsigned INPUT_SIZE        = 784;
   localparam int unsigned OUTPUT_SIZE       = 10;
   localparam int unsigned NUM_STEPS_DEFAULT = 32;
   localparam int unsigned NUM_STEPS         = NUM_STEPS_DEFAULT;
   localparam int unsigned CNT_WIDTH         = $clog2(NUM_STEPS + 1);
   localparam int unsigned CLS_WIDTH         = $clog2(OUTPUT_SIZE);
   localparam int unsigned LEAK_WIDTH        = 8;

   typedef logic [INPUT_SIZE-1:0][PIXEL_WIDTH-1:0] frame_t;
   typedef logic [OUTPUT_SIZE-1:0][CNT_WIDTH-1:0]  count_array_t;

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DECIDE, HOLD} snn_ctrl_state_e;

   typedef struct packed {
      logic [CLS_WIDTH-1:0] cls;
      logic [CNT_WIDTH-1:0] count;
      logic                 tie;
      logic                 none;
   } result_t;

   // Requested step count clamped into 1..NUM_STEPS.
   function automatic logic [CNT_WIDTH-1:0] eff_steps(input logic [CNT_WIDTH-1:0] req);
      if (req == '0)
         return CNT_WIDTH'(1);
      else if (req > CNT_WIDTH'(NUM_STEPS))
         return CNT_WIDTH'(NUM_STEPS);
      else
         return req;
   endfunction

endpackage

// File: rtl/snn_frame_controller_if.sv
// Frame, core and result signals between host/core (master) and the controller (slave).
interface snn_frame_controller_if;
   import snn_frame_controller_pkg::*;

   logic                   frame_valid;
   logic                   frame_ready;
   frame_t                 frame_pixels;
   logic [LEAK_WIDTH-1:0]  frame_leak;
   logic [CNT_WIDTH-1:0]   frame_steps;
   frame_t                 pixel_input;
   logic [LEAK_WIDTH-1:0]  leak_factor;
   logic                   core_clear;
   logic [OUTPUT_SIZE-1:0] digit_spikes;
   logic                   result_valid;
   logic                   result_ready;
   logic [CLS_WIDTH-1:0]   result_class;
   logic [CNT_WIDTH-1:0]   result_count;
   logic                   result_tie;
   logic                   result_none;

   modport master (
      output frame_valid, frame_pixels, frame_leak, frame_steps, digit_spikes, result_ready,
      input  frame_ready, pixel_input, leak_factor, core_clear,
             result_valid, result_class, result_count, result_tie, result_none
   );

   modport slave (
      input  frame_valid, frame_pixels, frame_leak, frame_steps, digit_spikes, result_ready,
      output frame_ready, pixel_input, leak_factor, core_clear,
             result_valid, result_class, result_count, result_tie, result_none
   );

endinterface

// File: rtl/snn_spike_counter_bank.sv
// Per-class spike counters, cleared at frame start and advanced while enabled.
module snn_spike_counter_bank
   import snn_frame_controller_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   enable,
   input  logic [OUTPUT_SIZE-1:0] spikes,
   output count_array_t           counts
);

   count_array_t counts_q, counts_d;

   // Next counts: clear wins over enable; no saturation since counts never exceed S.
   always_comb begin
      counts_d = counts_q;
      if (clear) begin
         counts_d = '0;
      end else if (enable) begin
         for (int i = 0; i < int'(OUTPUT_SIZE); i++) begin
            if (spikes[i]) counts_d[i] = counts_q[i] + CNT_WIDTH'(1);
         end
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) counts_q <= '0;
      else        counts_q <= counts_d;
   end

   assign counts = counts_q;

endmodule

// File: rtl/snn_frame_controller.sv
// Frame sequencer: accepts a frame, runs the core for S steps, argmaxes spike counts.
module snn_frame_controller
   import snn_frame_controller_pkg::*;
(
   input logic                   clk,
   input logic                   rst_n,
   snn_frame_controller_if.slave bus
);

   snn_ctrl_state_e       state_q, state_d;
   logic [CNT_WIDTH-1:0]  steps_q, steps_d;
   logic [CNT_WIDTH-1:0]  step_cnt_q, step_cnt_d;
   logic [CLS_WIDTH-1:0]  scan_idx_q, scan_idx_d;
   logic [CNT_WIDTH-1:0]  best_cnt_q, best_cnt_d;
   logic [CLS_WIDTH-1:0]  best_idx_q, best_idx_d;
   logic                  tie_q, tie_d;
   frame_t                pixel_q, pixel_d;
   logic [LEAK_WIDTH-1:0] leak_q, leak_d;
   logic                  frame_ready_q, frame_ready_d;
   logic                  core_clear_q, core_clear_d;
   logic                  result_valid_q, result_valid_d;
   result_t               result_q, result_d;
   count_array_t          counts;
   logic [CNT_WIDTH-1:0]  cur_cnt;

   snn_spike_counter_bank u_counters (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state_q == CLEAR),
      .enable (state_q == RUN),
      .spikes (bus.digit_spikes),
      .counts (counts)
   );

   assign cur_cnt = counts[scan_idx_q];

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d        = state_q;
      steps_d        = steps_q;
      step_cnt_d     = step_cnt_q;
      scan_idx_d     = scan_idx_q;
      best_cnt_d     = best_cnt_q;
      best_idx_d     = best_idx_q;
      tie_d          = tie_q;
      pixel_d        = pixel_q;
      leak_d         = leak_q;
      result_d       = result_q;
      frame_ready_d  = 1'b0;
      core_clear_d   = 1'b0;
      result_valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.frame_valid && frame_ready_q) begin
               pixel_d = bus.frame_pixels;
               leak_d  = bus.frame_leak;
               steps_d = eff_steps(bus.frame_steps);
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            step_cnt_d = '0;
            scan_idx_d = '0;
            best_cnt_d = '0;
            best_idx_d = '0;
            tie_d      = 1'b0;
            state_d    = RUN;
         end
         RUN: begin
            step_cnt_d = step_cnt_q + CNT_WIDTH'(1);
            if (step_cnt_q == steps_q - CNT_WIDTH'(1)) state_d = DECIDE;
         end
         DECIDE: begin
            // Strictly greater replaces, so the lowest index keeps ties.
            if (cur_cnt > best_cnt_q) begin
               best_cnt_d = cur_cnt;
               best_idx_d = scan_idx_q;
               tie_d      = 1'b0;
            end else if ((cur_cnt == best_cnt_q) && (best_cnt_q != '0)) begin
               tie_d = 1'b1;
            end
            if (scan_idx_q == CLS_WIDTH'(OUTPUT_SIZE - 1)) begin
               result_d.cls   = best_idx_d;
               result_d.count = best_cnt_d;
               result_d.tie   = tie_d;
               result_d.none  = (best_cnt_d == '0);
               state_d        = HOLD;
            end else begin
               scan_idx_d = scan_idx_q + CLS_WIDTH'(1);
            end
         end
         HOLD: begin
            if (bus.result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      frame_ready_d  = (state_d == IDLE);
      core_clear_d   = (state_d == CLEAR);
      result_valid_d = (state_d == HOLD);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         steps_q        <= '0;
         step_cnt_q     <= '0;
         scan_idx_q     <= '0;
         best_cnt_q     <= '0;
         best_idx_q     <= '0;
         tie_q          <= 1'b0;
         pixel_q        <= '0;
         leak_q         <= '0;
         result_q       <= '0;
         frame_ready_q  <= 1'b0;
         core_clear_q   <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         steps_q        <= steps_d;
         step_cnt_q     <= step_cnt_d;
         scan_idx_q     <= scan_idx_d;
         best_cnt_q     <= best_cnt_d;
         best_idx_q     <= best_idx_d;
         tie_q          <= tie_d;
         pixel_q        <= pixel_d;
         leak_q         <= leak_d;
         result_q       <= result_d;
         frame_ready_q  <= frame_ready_d;
         core_clear_q   <= core_clear_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign bus.frame_ready  = frame_ready_q;
   assign bus.core_clear   = core_clear_q;
   assign bus.pixel_input  = pixel_q;
   assign bus.leak_factor  = leak_q;
   assign bus.result_valid = result_valid_q;
   assign bus.result_class = result_q.cls;
   assign bus.result_count = result_q.count;
   assign bus.result_tie   = result_q.tie;
   assign bus.result_none  = result_q.none;

endmodule

// File: tb/tb_snn_frame_controller.sv
// Directed, table-driven bench for snn_frame_controller.
module tb_snn_frame_controller;
   import snn_frame_controller_pkg::*;

   typedef struct {
      logic [CNT_WIDTH-1:0]   steps;
      int                     s_eff;
      logic [OUTPUT_SIZE-1:0] every;
      logic [OUTPUT_SIZE-1:0] odd;
      int                     cls;
      int                     cnt;
      bit                     tie;
      bit                     none;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   snn_frame_controller_if bus ();

   snn_frame_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".frame_ready"},  64'(bus.frame_ready),  64'd0);
      check({tag, ".core_clear"},   64'(bus.core_clear),   64'd0);
      check({tag, ".result_valid"}, 64'(bus.result_valid), 64'd0);
      check({tag, ".result_class"}, 64'(bus.result_class), 64'd0);
      check({tag, ".result_count"}, 64'(bus.result_count), 64'd0);
      check({tag, ".result_tie"},   64'(bus.result_tie),   64'd0);
      check({tag, ".result_none"},  64'(bus.result_none),  64'd0);
      check({tag, ".pixels_zero"},  64'(bus.pixel_input === '0), 64'd1);
      check({tag, ".leak_factor"},  64'(bus.leak_factor),  64'd0);
   endtask

   task automatic check_result(input string tag, input vec_t v);
      check({tag, ".class"}, 64'(bus.result_class), 64'(v.cls));
      check({tag, ".count"}, 64'(bus.result_count), 64'(v.cnt));
      check({tag, ".tie"},   64'(bus.result_tie),   64'(v.tie));
      check({tag, ".none"},  64'(bus.result_none),  64'(v.none));
   endtask

   // Offers one frame, plays the spike pattern and checks timing and result.
   task automatic run_frame(input vec_t v, input string name, input bit ready_early,
                            input int hold_cycles, input bit keep_valid, output int wait_cycles);
      frame_t          px;
      logic [7:0]      lk;
      int              first;
      for (int i = 0; i < int'(INPUT_SIZE); i++) px[i] = PIXEL_WIDTH'($urandom);
      lk = 8'($urandom);
      bus.frame_pixels = px;
      bus.frame_leak   = lk;
      bus.frame_steps  = v.steps;
      bus.frame_valid  = 1'b1;
      bus.digit_spikes = '1;
      bus.result_ready = ready_early;
      wait_cycles = 0;
      while (!bus.frame_ready && wait_cycles < 100) begin
         tick();
         wait_cycles++;
      end
      if (!bus.frame_ready) begin
         check({name, ".accept_timeout"}, 64'd0, 64'd1);
         bus.frame_valid = 1'b0;
         return;
      end
      tick();
      if (keep_valid) begin
         bus.frame_pixels = ~px;
         bus.frame_leak   = ~lk;
      end else begin
         bus.frame_valid = 1'b0;
      end
      check({name, ".ready_after_accept"}, 64'(bus.frame_ready), 64'd0);
      check({name, ".core_clear_hi"},      64'(bus.core_clear),  64'd1);
      check({name, ".pixel_latch"},        64'(bus.pixel_input == px), 64'd1);
      check({name, ".leak_latch"},         64'(bus.leak_factor), 64'(lk));
      tick();
      check({name, ".core_clear_lo"},      64'(bus.core_clear),  64'd0);
      for (int k = 0; k < v.s_eff; k++) begin
         bus.digit_spikes = v.every | (((k % 2) == 0) ? v.odd : '0);
         tick();
         if (bus.frame_ready !== 1'b0) check({name, ".ready_in_run"}, 64'(bus.frame_ready), 64'd0);
      end
      bus.digit_spikes = '1;
      first = -1;
      for (int e = v.s_eff + 2; e < v.s_eff + 40; e++) begin
         tick();
         if (bus.result_valid) begin
            first = e;
            break;
         end
      end
      check({name, ".latency"}, 64'(first), 64'(v.s_eff + 11));
      if (first < 0) return;
      check_result(name, v);
      for (int h = 0; h < hold_cycles; h++) begin
         tick();
         check({name, ".hold_valid"}, 64'(bus.result_valid), 64'd1);
         check({name, ".hold_ready"}, 64'(bus.frame_ready),  64'd0);
         check_result({name, ".hold"}, v);
      end
      bus.result_ready = 1'b1;
      tick();
      check({name, ".valid_dropped"}, 64'(bus.result_valid), 64'd0);
      check({name, ".ready_back"},    64'(bus.frame_ready),  64'd1);
      check({name, ".pixel_held"},    64'(bus.pixel_input == px), 64'd1);
      check({name, ".leak_held"},     64'(bus.leak_factor),  64'(lk));
      bus.result_ready = 1'b0;
      bus.digit_spikes = '0;
   endtask

   vec_t vecs[9];
   vec_t vrst;
   int   w;

   initial begin
      vecs[0] = '{steps: 6'd8,  s_eff: 8,  every: 10'h008, odd: 10'h080, cls: 3, cnt: 8,  tie: 0, none: 0};
      vecs[1] = '{steps: 6'd4,  s_eff: 4,  every: 10'h024, odd: 10'h000, cls: 2, cnt: 4,  tie: 1, none: 0};
      vecs[2] = '{steps: 6'd0,  s_eff: 1,  every: 10'h000, odd: 10'h000, cls: 0, cnt: 0,  tie: 0, none: 1};
      vecs[3] = '{steps: 6'd40, s_eff: 32, every: 10'h200, odd: 10'h000, cls: 9, cnt: 32, tie: 0, none: 0};
      vecs[4] = '{steps: 6'd6,  s_eff: 6,  every: 10'h040, odd: 10'h011, cls: 6, cnt: 6,  tie: 0, none: 0};
      vecs[5] = '{steps: 6'd5,  s_eff: 5,  every: 10'h000, odd: 10'h201, cls: 0, cnt: 3,  tie: 1, none: 0};
      vecs[6] = '{steps: 6'd32, s_eff: 32, every: 10'h000, odd: 10'h020, cls: 5, cnt: 16, tie: 0, none: 0};
      vecs[7] = '{steps: 6'd33, s_eff: 32, every: 10'h3FF, odd: 10'h000, cls: 0, cnt: 32, tie: 1, none: 0};
      vecs[8] = '{steps: 6'd1,  s_eff: 1,  every: 10'h010, odd: 10'h000, cls: 4, cnt: 1,  tie: 0, none: 0};
      vrst    = '{steps: 6'd3,  s_eff: 3,  every: 10'h080, odd: 10'h000, cls: 7, cnt: 3,  tie: 0, none: 0};

      rst_n = 1'b0;
      bus.frame_valid  = 1'b0;
      bus.frame_pixels = '0;
      bus.frame_leak   = '0;
      bus.frame_steps  = '0;
      bus.digit_spikes = '0;
      bus.result_ready = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();
      check("reset.ready_first_cycle", 64'(bus.frame_ready), 64'd1);

      // Table: result_ready already high, so result_valid must last one cycle.
      for (int i = 0; i < 9; i++) begin
         run_frame(vecs[i], $sformatf("vec%0d", i), 1'b1, 0, 1'b0, w);
      end

      // Stall: frame_valid held through the run, consumer late by 5 cycles.
      run_frame(vecs[0], "stall", 1'b0, 5, 1'b1, w);
      run_frame(vecs[1], "stall_next", 1'b1, 0, 1'b0, w);
      check("stall_next.accept_wait", 64'(w), 64'd0);

      // Reset mid-run, then a clean frame.
      bus.frame_pixels = '1;
      bus.frame_leak   = 8'hA5;
      bus.frame_steps  = 6'd8;
      bus.frame_valid  = 1'b1;
      bus.digit_spikes = 10'h008;
      w = 0;
      while (!bus.frame_ready && w < 100) begin
         tick();
         w++;
      end
      check("midrst.ready_before", 64'(bus.frame_ready), 64'd1);
      tick();
      bus.frame_valid = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      bus.digit_spikes = '0;
      tick();
      check("midrst.ready_first_cycle", 64'(bus.frame_ready), 64'd1);
      run_frame(vrst, "after_rst", 1'b1, 0, 1'b0, w);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
